// File: rtl/apb4_ms_slave_if.sv
// APB4 bus bundle between one requester and the storage slave.
// Carries the select/enable handshake, address/data/strobe/protection and the response.
interface apb4_ms_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    PSELx;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic                    PREADY;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb4_ms_slave.sv
// APB4 register-file slave: DEPTH words with byte strobes, programmable wait states,
// address/alignment/privilege error responses and a saturating error counter.
module apb4_ms_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int PROT_CHECK  = 1
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb4_ms_slave_if.slave   apb,
  output logic [7:0]       err_count
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic                  err_q, err_d;
  logic                  write_q, write_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  range_err, misaligned, prot_err, setup_err;
  logic                  pready;
  logic                  unused_prot;

  // Error classification is done once, on the setup-phase address and controls.
  assign word_idx    = apb.PADDR >> LSB;
  assign range_err   = word_idx >= ADDR_WIDTH'(DEPTH);
  assign misaligned  = |(apb.PADDR & LSB_MASK);
  assign prot_err    = (PROT_CHECK != 0) && apb.PWRITE && !apb.PPROT[0];
  assign setup_err   = range_err || misaligned || prot_err;
  assign unused_prot = ^apb.PPROT[2:1];

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    write_d     = write_q;
    idx_d       = idx_q;
    rdata_d     = rdata_q;
    err_count_d = err_count_q;
    mem_d       = mem_q;
    case (state_q)
      IDLE: begin
        if (apb.PSELx && !apb.PENABLE) begin
          state_d = ACCESS;
          wcnt_d  = 3'(WAIT_STATES);
          err_d   = setup_err;
          write_d = apb.PWRITE;
          idx_d   = word_idx[IDX_W-1:0];
          rdata_d = setup_err ? '0 : mem_q[word_idx[IDX_W-1:0]];
        end
      end
      ACCESS: begin
        if (!apb.PSELx) begin
          // Requester abandoned the transfer: nothing is committed.
          state_d = IDLE;
          wcnt_d  = 3'd0;
        end else if (wcnt_q != 3'd0) begin
          wcnt_d = wcnt_q - 3'd1;
        end else begin
          state_d = IDLE;
          if (err_q) begin
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end else if (write_q) begin
            for (int b = 0; b < NB; b++) begin
              if (apb.PSTRB[b]) mem_d[idx_q][8*b +: 8] = apb.PWDATA[8*b +: 8];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      wcnt_q      <= 3'd0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      rdata_q     <= '0;
      err_count_q <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      rdata_q     <= rdata_d;
      err_count_q <= err_count_d;
      mem_q       <= mem_d;
    end
  end

  // Response is gated so data and error only appear during the completing cycle.
  assign pready      = (state_q == ACCESS) && (wcnt_q == 3'd0);
  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pready && err_q;
  assign apb.PRDATA  = (pready && !err_q && !write_q) ? rdata_q : '0;
  assign err_count   = err_count_q;
endmodule

// File: tb/tb_apb4_ms_slave.sv
// Bench for apb4_ms_slave: two instances (0 and 3 wait states) driven by directed and
// random APB transfers, checked against a word-array/counter model of the slave.
module tb_apb4_ms_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        psel [2];
  logic        penable [2];
  logic        pwrite [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [3:0]  pstrb [2];
  logic [2:0]  pprot [2];
  logic        rst_n [2];
  logic        pready_o [2];
  logic [31:0] prdata_o [2];
  logic        pslverr_o [2];
  logic [7:0]  ecnt_o [2];
  logic [7:0]  ecnt0, ecnt3;

  int          ws [2] = '{0, 3};
  logic [31:0] model [2][16];
  int          exp_ecnt [2];

  apb4_ms_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  apb4_ms_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus3 ();

  assign bus0.PSELx = psel[0];   assign bus3.PSELx = psel[1];
  assign bus0.PENABLE = penable[0]; assign bus3.PENABLE = penable[1];
  assign bus0.PWRITE = pwrite[0]; assign bus3.PWRITE = pwrite[1];
  assign bus0.PADDR = paddr[0];  assign bus3.PADDR = paddr[1];
  assign bus0.PWDATA = pwdata[0]; assign bus3.PWDATA = pwdata[1];
  assign bus0.PSTRB = pstrb[0];  assign bus3.PSTRB = pstrb[1];
  assign bus0.PPROT = pprot[0];  assign bus3.PPROT = pprot[1];
  assign pready_o[0] = bus0.PREADY;   assign pready_o[1] = bus3.PREADY;
  assign prdata_o[0] = bus0.PRDATA;   assign prdata_o[1] = bus3.PRDATA;
  assign pslverr_o[0] = bus0.PSLVERR; assign pslverr_o[1] = bus3.PSLVERR;
  assign ecnt_o[0] = ecnt0;           assign ecnt_o[1] = ecnt3;

  apb4_ms_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(0), .PROT_CHECK(1))
    u_dut0 (.PCLK(clk), .PRESETn(rst_n[0]), .apb(bus0), .err_count(ecnt0));
  apb4_ms_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(3), .PROT_CHECK(1))
    u_dut3 (.PCLK(clk), .PRESETn(rst_n[1]), .apb(bus3), .err_count(ecnt3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = 3'b000;
  endtask

  task automatic model_clear(input int d);
    for (int i = 0; i < 16; i++) model[d][i] = '0;
    exp_ecnt[d] = 0;
  endtask

  task automatic check_quiet(input int d, input string tag);
    check({tag, "_pready"}, {31'd0, pready_o[d]}, 32'd0);
    check({tag, "_prdata"}, prdata_o[d], 32'd0);
    check({tag, "_pslverr"}, {31'd0, pslverr_o[d]}, 32'd0);
    check({tag, "_errcnt"}, {24'd0, ecnt_o[d]}, exp_ecnt[d]);
  endtask

  // One complete transfer; returns at the negedge where PREADY is seen high, so a
  // following call issues its setup phase with no idle cycle in between.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input string tag);
    int          idx;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          cyc;
    bit          got;
    idx     = int'(addr >> 2);
    exp_err = (idx >= 16) || (addr[1:0] != 2'b00) || (wr && !prot[0]);
    exp_rd  = '0;
    if (!wr && !exp_err) exp_rd = model[d][idx];
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
    pwdata[d] = wdata; pstrb[d] = strb; pprot[d] = prot;
    @(negedge clk);
    penable[d] = 1'b1;
    cyc = 2;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pready_o[d]) begin
        got = 1'b1;
        break;
      end
      check({tag, "_waitdata"}, prdata_o[d], 32'd0);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ready_seen"}, {31'd0, pready_o[d]}, 32'd1);
    check({tag, "_prdata"}, prdata_o[d], exp_rd);
    check({tag, "_pslverr"}, {31'd0, pslverr_o[d]}, {31'd0, exp_err});
    check({tag, "_cycles"}, cyc, ws[d] + 2);
    $display("[TB] dut%0d %s %s addr=%h wdata=%h strb=%h prot=%0d -> prdata=%h slverr=%0d cycles=%0d",
             d, tag, wr ? "WR" : "RD", addr, wdata, strb, prot, prdata_o[d], pslverr_o[d], cyc);
    if (got) begin
      if (exp_err) begin
        if (exp_ecnt[d] < 255) exp_ecnt[d]++;
      end else if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [3:0]  rs;
    logic [2:0]  rp;
    bit          rw;
    int          sel;

    for (int d = 0; d < 2; d++) begin
      bus_idle(d);
      model_clear(d);
      rst_n[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_quiet(0, "reset0");
    check_quiet(1, "reset3");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Basic write/read round trip and strobed partial write.
    xfer(0, 1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b001, "wr_default");
    xfer(0, 0, 32'h4, 32'h0, 4'h0, 3'b001, "rd_default");
    check("rd_default_const", prdata_o[0], 32'hDEADBEEF);
    xfer(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, 3'b001, "wr_base8");
    xfer(0, 1, 32'h8, 32'h11223344, 4'b0101, 3'b001, "wr_strb");
    xfer(0, 0, 32'h8, 32'h0, 4'h0, 3'b000, "rd_strb");
    check("rd_strb_const", prdata_o[0], 32'hDE22BE44);
    xfer(0, 1, 32'h8, 32'hFFFFFFFF, 4'h0, 3'b001, "wr_nostrb");
    xfer(0, 0, 32'h8, 32'h0, 4'hF, 3'b001, "rd_nostrb");

    // Error responses: out of range, misaligned, unprivileged write.
    xfer(0, 1, 32'h40, 32'hCAFEF00D, 4'hF, 3'b001, "err_range");
    xfer(0, 1, 32'h2, 32'hCAFEF00D, 4'hF, 3'b001, "err_misal");
    xfer(0, 1, 32'h4, 32'hCAFEF00D, 4'hF, 3'b000, "err_prot");
    @(negedge clk);
    bus_idle(0);
    check("err_count3", {24'd0, ecnt_o[0]}, 32'd3);
    xfer(0, 0, 32'h4, 32'h0, 4'h0, 3'b000, "rd_after_err4");
    xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b000, "rd_after_err0");

    // PENABLE high while idle is not a setup phase.
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h4;
    pwdata[0] = 32'h12345678; pstrb[0] = 4'hF; pprot[0] = 3'b001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_penable_pready", {31'd0, pready_o[0]}, 32'd0);
    end
    bus_idle(0);
    xfer(0, 0, 32'h4, 32'h0, 4'h0, 3'b001, "rd_after_idle_pen");

    // Random back-to-back traffic.
    for (int n = 0; n < 80; n++) begin
      rw  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 7)       ra = 32'($urandom_range(0, 15) * 4);
      else if (sel == 7) ra = 32'($urandom_range(16, 40) * 4);
      else               ra = 32'($urandom_range(0, 63));
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
      rp = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) rp[0] = 1'b1;
      xfer(0, rw, ra, rd, rs, rp, "rand");
    end
    @(negedge clk);
    bus_idle(0);
    check("rand_errcnt", {24'd0, ecnt_o[0]}, exp_ecnt[0]);

    // Saturation of the error counter.
    for (int n = 0; n < 260; n++) xfer(0, 1, 32'h40, 32'h0, 4'hF, 3'b001, "sat");
    @(negedge clk);
    bus_idle(0);
    check("sat_errcnt", {24'd0, ecnt_o[0]}, 32'd255);
    check("sat_errcnt_model", {24'd0, ecnt_o[0]}, exp_ecnt[0]);

    // Reset arriving in the completing access cycle wins over the write.
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h4;
    pwdata[0] = 32'h55555555; pstrb[0] = 4'hF; pprot[0] = 3'b001;
    @(negedge clk);
    penable[0] = 1'b1;
    rst_n[0] = 1'b0;
    @(negedge clk);
    bus_idle(0);
    model_clear(0);
    check_quiet(0, "rst_mid");
    rst_n[0] = 1'b1;
    xfer(0, 0, 32'h4, 32'h0, 4'h0, 3'b001, "rd_after_rst4");
    xfer(0, 0, 32'h3C, 32'h0, 4'h0, 3'b001, "rd_after_rst3c");
    @(negedge clk);
    bus_idle(0);

    // Wait-state instance: latency, then aborts after one wait cycle.
    xfer(1, 0, 32'h4, 32'h0, 4'h0, 3'b001, "ws3_rd");
    xfer(1, 1, 32'h4, 32'hA1B2C3D4, 4'hF, 3'b001, "ws3_wr");
    xfer(1, 0, 32'h4, 32'h0, 4'h0, 3'b001, "ws3_rd2");
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
      paddr[1] = (t == 0) ? 32'h10 : 32'h40;
      pwdata[1] = 32'hAAAAAAAA; pstrb[1] = 4'hF; pprot[1] = 3'b001;
      @(negedge clk);
      penable[1] = 1'b1;
      check("abort_wait_pready", {31'd0, pready_o[1]}, 32'd0);
      @(negedge clk);
      bus_idle(1);
      for (int k = 0; k < 4; k++) begin
        check("abort_pready", {31'd0, pready_o[1]}, 32'd0);
        @(negedge clk);
      end
    end
    check("abort_errcnt", {24'd0, ecnt_o[1]}, exp_ecnt[1]);
    xfer(1, 0, 32'h10, 32'h0, 4'h0, 3'b001, "rd_after_abort");
    @(negedge clk);
    bus_idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
